// File: rtl/mem_pkg.sv
// Shared MemoryCore port B types and widths.
package mem_pkg;

    localparam int unsigned ADDR_W = 15;
    localparam int unsigned DATA_W = 16;

    typedef enum logic {
        REQ0 = 1'b0,
        REQ1 = 1'b1
    } reqId_t;

    typedef struct packed {
        logic   valid;
        reqId_t id;
    } rdTag_t;

endpackage

// File: rtl/mem_rd_tag_pipe.sv
// Read-tag delay line: tracks which requester owns each in-flight read so
// the returning data can be steered. Depth covers the address register plus
// the RAM read latency.
module mem_rd_tag_pipe
    import mem_pkg::*;
#(
    parameter int unsigned RD_LAT = 1
) (
    input  logic   CLK,
    input  logic   RST,
    input  rdTag_t tagIn,
    output rdTag_t tagOut
);

    localparam int unsigned DEPTH = RD_LAT + 1;

    rdTag_t stage [DEPTH];

    // Shift tags one stage per cycle; reset drops every in-flight tag.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= tagIn;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign tagOut = stage[DEPTH-1];

endmodule

// File: rtl/mem_portb_arbiter.sv
// Round-robin arbiter sharing MemoryCore port B between two requesters,
// with bounded bursts and tagged read-data return.
module mem_portb_arbiter #(
    parameter int unsigned ADDR_W    = mem_pkg::ADDR_W,
    parameter int unsigned DATA_W    = mem_pkg::DATA_W,
    parameter int unsigned RD_LAT    = 1,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic              CLK,
    input  logic              RST,

    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic              rvalid0,

    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic              rvalid1,

    output logic [DATA_W-1:0] rdata,

    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);

    import mem_pkg::*;

    localparam int unsigned      CNT_W   = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    reqId_t            owner;
    reqId_t            ownerNext;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cntNext;
    reqId_t            winner;
    logic              anyGnt;
    logic              winWe;
    logic [ADDR_W-1:0] winAddr;
    logic [DATA_W-1:0] winData;
    rdTag_t            tagIn;
    rdTag_t            tagOut;

    // Pick the winner and compute the next owner/burst count.
    always_comb begin
        winner    = REQ0;
        ownerNext = owner;
        cntNext   = cnt;
        anyGnt    = (req0 || req1) && !RST;

        if (req0 && req1) begin
            // Owner keeps the port until its burst budget is spent.
            if (cnt < CNT_MAX) begin
                winner = owner;
            end else begin
                winner = (owner == REQ0) ? REQ1 : REQ0;
            end
        end else if (req1) begin
            winner = REQ1;
        end

        if (anyGnt) begin
            if (winner == owner) begin
                cntNext = (cnt == CNT_MAX) ? CNT_MAX : cnt + CNT_ONE;
            end else begin
                ownerNext = winner;
                cntNext   = CNT_ONE;
            end
        end
    end

    // Arbitration state register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            owner <= REQ1;
            cnt   <= CNT_MAX;
        end else begin
            owner <= ownerNext;
            cnt   <= cntNext;
        end
    end

    assign gnt0 = anyGnt && (winner == REQ0);
    assign gnt1 = anyGnt && (winner == REQ1);

    assign winWe   = (winner == REQ1) ? we1    : we0;
    assign winAddr = (winner == REQ1) ? addr1  : addr0;
    assign winData = (winner == REQ1) ? wdata1 : wdata0;

    // Port B pin registers; address/data hold when idle so only we drops.
    always_ff @(posedge CLK) begin
        if (RST) begin
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_din  <= '0;
        end else if (anyGnt) begin
            mem_we   <= winWe;
            mem_addr <= winAddr;
            mem_din  <= winData;
        end else begin
            mem_we   <= 1'b0;
        end
    end

    assign tagIn = '{valid: anyGnt && !winWe, id: winner};

    mem_rd_tag_pipe #(
        .RD_LAT (RD_LAT)
    ) u_tagPipe (
        .CLK    (CLK),
        .RST    (RST),
        .tagIn  (tagIn),
        .tagOut (tagOut)
    );

    // Steer the returning read to its issuer; nothing returns during reset.
    assign rvalid0 = tagOut.valid && (tagOut.id == REQ0) && !RST;
    assign rvalid1 = tagOut.valid && (tagOut.id == REQ1) && !RST;
    assign rdata   = mem_dout;

endmodule

// File: tb/tb_mem_portb_arbiter.sv
// Randomized and directed bench for mem_portb_arbiter with a behavioural
// arbiter/memory reference model and a registered-read MemoryCore stand-in.
module tb_mem_portb_arbiter;

    localparam int AW        = 15;
    localparam int DW        = 16;
    localparam int RD_LAT    = 1;
    localparam int MAX_BURST = 4;
    localparam int NSLOT     = 8;
    localparam int MEMSZ     = 1 << AW;

    logic          CLK = 1'b0;
    logic          RST;
    logic          req0, we0, req1, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1, rvalid0, rvalid1;
    logic [DW-1:0] rdata;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_dout;

    always #5 CLK = ~CLK;

    mem_portb_arbiter #(
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .RD_LAT    (RD_LAT),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .req0     (req0),
        .we0      (we0),
        .addr0    (addr0),
        .wdata0   (wdata0),
        .gnt0     (gnt0),
        .rvalid0  (rvalid0),
        .req1     (req1),
        .we1      (we1),
        .addr1    (addr1),
        .wdata1   (wdata1),
        .gnt1     (gnt1),
        .rvalid1  (rvalid1),
        .rdata    (rdata),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_din  (mem_din),
        .mem_dout (mem_dout)
    );

    function automatic logic [DW-1:0] initVal(input int a);
        return DW'(a * 40503 + 4660);
    endfunction

    // MemoryCore port B stand-in: registered read, contents restored on reset.
    logic [DW-1:0] core [MEMSZ];
    always @(posedge CLK) begin
        if (RST) begin
            for (int a = 0; a < MEMSZ; a++) core[a] <= initVal(a);
        end else if (mem_we) begin
            core[mem_addr] <= mem_din;
        end
        mem_dout <= core[mem_addr];
    end

    // Reference model state
    logic [DW-1:0] refMem [MEMSZ];
    int            mOwner, mCnt;
    logic          expWe;
    logic [AW-1:0] expAddr;
    logic [DW-1:0] expDin;
    bit            evV    [NSLOT];
    int            evId   [NSLOT];
    logic [DW-1:0] evData [NSLOT];
    int            cyc;
    int            lastWin;
    int            nChecks;
    int            nErrors;

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nErrors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Check the sampled cycle against the model, then advance the model.
    task automatic modelCheck();
        int            win;
        int            slot;
        int            s2;
        logic          w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;

        if (RST)                win = -1;
        else if (req0 && req1)  win = (mCnt < MAX_BURST) ? mOwner : 1 - mOwner;
        else if (req0)          win = 0;
        else if (req1)          win = 1;
        else                    win = -1;

        checkEq("gnt0", 32'(gnt0), 32'(win == 0));
        checkEq("gnt1", 32'(gnt1), 32'(win == 1));
        checkEq("mem_we", 32'(mem_we), 32'(expWe));
        checkEq("mem_addr", 32'(mem_addr), 32'(expAddr));
        checkEq("mem_din", 32'(mem_din), 32'(expDin));

        slot = cyc % NSLOT;
        if (RST) begin
            checkEq("rvalid0 in reset", 32'(rvalid0), 32'd0);
            checkEq("rvalid1 in reset", 32'(rvalid1), 32'd0);
        end else begin
            checkEq("rvalid0", 32'(rvalid0), 32'(evV[slot] && evId[slot] == 0));
            checkEq("rvalid1", 32'(rvalid1), 32'(evV[slot] && evId[slot] == 1));
            if (evV[slot]) checkEq("rdata", 32'(rdata), 32'(evData[slot]));
        end
        evV[slot] = 1'b0;

        if (RST) begin
            for (int s = 0; s < NSLOT; s++) evV[s] = 1'b0;
            for (int i = 0; i < MEMSZ; i++) refMem[i] = initVal(i);
            mOwner  = 1;
            mCnt    = MAX_BURST;
            expWe   = 1'b0;
            expAddr = '0;
            expDin  = '0;
        end else if (win >= 0) begin
            w = (win == 1) ? we1    : we0;
            a = (win == 1) ? addr1  : addr0;
            d = (win == 1) ? wdata1 : wdata0;
            if (w) begin
                refMem[a] = d;
            end else begin
                s2         = (cyc + 1 + RD_LAT) % NSLOT;
                evV[s2]    = 1'b1;
                evId[s2]   = win;
                evData[s2] = refMem[a];
            end
            expWe   = w;
            expAddr = a;
            expDin  = d;
            if (win == mOwner) begin
                mCnt = (mCnt < MAX_BURST) ? mCnt + 1 : MAX_BURST;
            end else begin
                mOwner = win;
                mCnt   = 1;
            end
        end else begin
            expWe = 1'b0;
        end
        lastWin = win;
        cyc++;
    endtask

    task automatic stepCycle(input logic rst,
                             input logic r0, input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                             input logic r1, input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        @(posedge CLK);
        #1;
        RST = rst;
        req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
        req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
        @(negedge CLK);
        modelCheck();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) stepCycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    endtask

    function automatic logic [AW-1:0] pickAddr();
        case ($urandom_range(5))
            0:       return '0;
            1:       return 15'h7FFF;
            2, 3:    return AW'(16 + $urandom_range(3));
            default: return AW'($urandom);
        endcase
    endfunction

    bit            pend [2];
    bit            pw   [2];
    logic [AW-1:0] pa   [2];
    logic [DW-1:0] pd   [2];

    initial begin
        int seq;
        int cnt0;
        int cnt1;
        logic rst;

        nChecks = 0; nErrors = 0; cyc = 0; lastWin = -1;
        mOwner = 1; mCnt = MAX_BURST;
        expWe = 1'b0; expAddr = '0; expDin = '0;
        for (int s = 0; s < NSLOT; s++) begin evV[s] = 1'b0; evId[s] = 0; evData[s] = '0; end
        RST = 1'b1;
        req0 = 1'b1; we0 = 1'b0; addr0 = '0; wdata0 = '0;
        req1 = 1'b1; we1 = 1'b0; addr1 = '0; wdata1 = '0;

        // Reset held with both requesting
        for (int i = 0; i < 3; i++) begin
            stepCycle(1'b1, 1'b1, 1'b0, 15'h0001, '0, 1'b1, 1'b0, 15'h0002, '0);
            checkEq("t1 gnt", 32'({gnt0, gnt1}), 32'd0);
            checkEq("t1 mem_addr", 32'(mem_addr), 32'd0);
        end
        idle(1);

        // Single read
        stepCycle(1'b0, 1'b1, 1'b0, 15'h0010, '0, 1'b0, 1'b0, '0, '0);
        checkEq("t2 gnt0", 32'(gnt0), 32'd1);
        idle(1);
        checkEq("t2 mem_addr", 32'(mem_addr), 32'h0010);
        idle(1);
        checkEq("t2 rvalid0", 32'(rvalid0), 32'd1);
        checkEq("t2 rdata", 32'(rdata), 32'(initVal(16)));
        idle(2);

        // Write then read of the same address by the other requester
        stepCycle(1'b0, 1'b1, 1'b1, 15'h7FFF, 16'hBEEF, 1'b0, 1'b0, '0, '0);
        stepCycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 15'h7FFF, '0);
        checkEq("t3 mem_we", 32'(mem_we), 32'd1);
        checkEq("t3 mem_din", 32'(mem_din), 32'hBEEF);
        idle(2);
        checkEq("t3 rvalid1", 32'(rvalid1), 32'd1);
        checkEq("t3 rdata", 32'(rdata), 32'hBEEF);
        idle(2);

        // Contention from reset: bursts of MAX_BURST alternating
        stepCycle(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        cnt0 = 0; cnt1 = 0;
        for (int i = 0; i < 16; i++) begin
            stepCycle(1'b0, 1'b1, 1'b0, 15'h0020, '0, 1'b1, 1'b0, 15'h0030, '0);
            seq = gnt1 ? 1 : (gnt0 ? 0 : 9);
            checkEq($sformatf("t4 winner[%0d]", i), 32'(seq), 32'((i / MAX_BURST) % 2));
            cnt0 += int'(rvalid0); cnt1 += int'(rvalid1);
        end
        for (int i = 0; i < 2; i++) begin
            idle(1);
            cnt0 += int'(rvalid0); cnt1 += int'(rvalid1);
        end
        checkEq("t4 rvalid0 count", 32'(cnt0), 32'd8);
        checkEq("t4 rvalid1 count", 32'(cnt1), 32'd8);
        idle(1);

        // Single requester: no burst limit
        cnt1 = 0; seq = 0;
        for (int i = 0; i < 12; i++) begin
            if (i < 10) begin
                stepCycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, AW'(64 + i), '0);
                seq += int'(gnt1);
            end else begin
                idle(1);
            end
            cnt1 += int'(rvalid1);
        end
        checkEq("t5 gnt1 count", 32'(seq), 32'd10);
        checkEq("t5 rvalid1 count", 32'(cnt1), 32'd10);
        idle(1);

        // Reset while a read is in flight
        stepCycle(1'b0, 1'b1, 1'b0, 15'h0041, '0, 1'b0, 1'b0, '0, '0);
        stepCycle(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        idle(1);
        checkEq("t6 rvalid0 dropped", 32'(rvalid0), 32'd0);
        stepCycle(1'b0, 1'b1, 1'b0, 15'h0041, '0, 1'b0, 1'b0, '0, '0);
        idle(2);
        checkEq("t6 rvalid0 after reset", 32'(rvalid0), 32'd1);
        checkEq("t6 rdata", 32'(rdata), 32'(initVal(65)));

        // Random traffic with occasional resets
        for (int r = 0; r < 2; r++) pend[r] = 1'b0;
        for (int k = 0; k < 2500; k++) begin
            for (int r = 0; r < 2; r++) begin
                if (!pend[r] && $urandom_range(99) < 65) begin
                    pend[r] = 1'b1;
                    pw[r]   = ($urandom_range(2) == 0);
                    pa[r]   = pickAddr();
                    pd[r]   = DW'($urandom);
                end
            end
            rst = ($urandom_range(199) == 0);
            stepCycle(rst, pend[0], pw[0], pa[0], pd[0], pend[1], pw[1], pa[1], pd[1]);
            if (lastWin >= 0) pend[lastWin] = 1'b0;
        end
        idle(4);

        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule

// File: doc/mem_portb_arbiter.md
Name: mem_portb_arbiter

Overview:
- Round-robin arbiter that shares port B of the dual-port MemoryCore (15-bit word address, 16-bit data) between two requesters, e.g. a display scan-out reader and a DMA/loader engine.
- Port A stays dedicated to the CPU and is not touched by this block.
- Registers the winning request onto the port B pins and routes the read data back to the requester that issued the read, using a tagged return pipeline.

Parameters:
- ADDR_W, 15, port B word-address width
- DATA_W, 16, data width
- RD_LAT, 1, cycles from the address appearing on mem_addr until mem_dout is valid (block RAM registered read)
- MAX_BURST, 4, maximum number of consecutive grants to one requester while the other is requesting

Ports:
- CLK  in  1  system clock, all logic rising-edge
- RST  in  1  synchronous, active-high reset
- req0  in  1  requester 0 access request, held until granted
- we0  in  1  requester 0: 1 = write, 0 = read
- addr0  in  ADDR_W  requester 0 word address
- wdata0  in  DATA_W  requester 0 write data
- gnt0  out  1  requester 0 accepted this cycle (combinational)
- rvalid0  out  1  read data for requester 0 valid this cycle
- req1, we1, addr1, wdata1, gnt1, rvalid1: same as requester 0, for requester 1
- rdata  out  DATA_W  shared read data, equal to mem_dout
- mem_we  out  1  to MemoryCore web
- mem_addr  out  ADDR_W  to MemoryCore addrb
- mem_din  out  DATA_W  to MemoryCore dinb
- mem_dout  in  DATA_W  from MemoryCore doutb

Behaviour:
- Handshake:
  - A transfer is accepted in cycle N when reqX && gntX.
  - Requesters must hold weX, addrX and wdataX stable while reqX is high and ungranted.
  - At most one gnt is high per cycle. gnt is never high without the matching req.
- Arbitration state: owner (1 bit) and cnt (0..MAX_BURST).
  - Reset values: owner=1, cnt=MAX_BURST, so requester 0 wins the first contention.
- Winner selection:
  - Only one req high: that requester wins.
  - Both high and cnt<MAX_BURST: the owner wins.
  - Both high and cnt==MAX_BURST: the non-owner wins.
- State update, only on a grant:
  - Winner==owner: cnt=min(cnt+1, MAX_BURST).
  - Otherwise: owner=winner, cnt=1.
  - Idle cycles leave the state unchanged.
- Memory side, registered:
  - At the edge ending accept cycle N, mem_we/mem_addr/mem_din load the winner's we/addr/wdata.
  - Cycle with no grant: mem_we=0, mem_addr and mem_din hold their previous values.
- Read return:
  - A read accepted in cycle N presents its address in N+1, and rvalidX pulses for exactly one cycle in N+1+RD_LAT.
  - rdata=mem_dout in that cycle.
  - Writes produce no rvalid.
  - Back-to-back reads return in issue order, one per cycle.
- Ordering: a write accepted in N followed by a read of the same address accepted in N+1 (either requester) returns the new data.
- Reset:
  - While RST=1: gnt0=gnt1=0, mem_we=0, mem_addr=0, mem_din=0, rvalid0=rvalid1=0, arbitration state reset.
  - Reset mid-operation discards all in-flight read tags; no rvalid appears after reset deasserts for reads accepted before it.
- Port A / port B same-address collisions are not arbitrated here; behaviour is as defined by MemoryCore.

Decomposition:
- Shared package mem_pkg holds:
  - ADDR_W=15 and DATA_W=16 constants, shared with the Control wrapper
  - requester-id typedef (REQ0, REQ1)
  - read-tag struct {valid, id}
- Sub-module mem_rd_tag_pipe: shift register of read tags, depth RD_LAT+1, synchronous clear on RST. Its output decodes to rvalid0/rvalid1.
- Arbitration logic and the port B registers stay in the top module.

Test Plan:
1. Reset: hold RST=1 for 3 cycles with req0=req1=1 -> gnt0=gnt1=0, mem_we=0, mem_addr=0, rvalid0=rvalid1=0 throughout.
2. Single read: req0=1, we0=0, addr0=15'h0010 for one cycle N -> gnt0=1 in N; mem_addr=15'h0010 with mem_we=0 in N+1; rvalid0=1 in N+2 with rdata equal to the model value; rvalid1 stays 0.
3. Write then read: req0 writes 16'hBEEF to 15'h7FFF in N; req1 reads 15'h7FFF in N+1 -> mem_we=1, mem_din=16'hBEEF in N+1; rvalid1=1 with rdata=16'hBEEF in N+3.
4. Contention: after reset hold req0=req1=1 (reads) for 16 cycles with MAX_BURST=4 -> grants follow 0,0,0,0,1,1,1,1,0,0,0,0,1,1,1,1 with no idle cycle; the rvalid sequence matches, delayed by 2 cycles.
5. Single requester: only req1=1 for 10 cycles -> gnt1=1 in all 10 cycles (burst limit not applied); 10 rvalid1 pulses in consecutive cycles.
6. Reset mid-read: req0 read accepted in N, RST=1 in N+1 only -> no rvalid0 in N+2; the next read accepted after reset returns normally with 2-cycle latency.
